// File: rtl/seg7_pkg.sv
// seg7_pkg
//   Shared definitions for the multiplexed 7-segment display driver:
//   the segment vector type, bit positions of segments a..g within it,
//   and the segment patterns for codes 0-F plus all-off.
//   Segment vector layout: [6]=a [5]=b [4]=c [3]=d [2]=e [1]=f [0]=g, active-high.

package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam int SEG_BIT_A = 6;
    localparam int SEG_BIT_B = 5;
    localparam int SEG_BIT_C = 4;
    localparam int SEG_BIT_D = 3;
    localparam int SEG_BIT_E = 2;
    localparam int SEG_BIT_F = 1;
    localparam int SEG_BIT_G = 0;

    localparam seg7_t SEG_BLANK = 7'b0000000;
    localparam seg7_t SEG_0     = 7'b1111110;
    localparam seg7_t SEG_1     = 7'b0110000;
    localparam seg7_t SEG_2     = 7'b1101101;
    localparam seg7_t SEG_3     = 7'b1111001;
    localparam seg7_t SEG_4     = 7'b0110011;
    localparam seg7_t SEG_5     = 7'b1011011;
    localparam seg7_t SEG_6     = 7'b1011111;
    localparam seg7_t SEG_7     = 7'b1110000;
    localparam seg7_t SEG_8     = 7'b1111111;
    localparam seg7_t SEG_9     = 7'b1111011;
    localparam seg7_t SEG_HA    = 7'b1110111;
    localparam seg7_t SEG_HB    = 7'b0011111;
    localparam seg7_t SEG_HC    = 7'b1001110;
    localparam seg7_t SEG_HD    = 7'b0111101;
    localparam seg7_t SEG_HE    = 7'b1001111;
    localparam seg7_t SEG_HF    = 7'b1000111;

    // Single-segment mask, e.g. seg_mask(SEG_BIT_G) isolates the middle bar.
    function automatic seg7_t seg_mask(input int bit_pos);
        seg7_t m;
        m = SEG_BLANK;
        m[bit_pos] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode
//   Combinational BCD/hex code to 7-segment pattern decoder.
//   Ports:
//     code     in  [3:0]  digit code
//     hex_mode in         1: codes 10-15 show A,b,C,d,E,F; 0: those codes blank
//     seg      out seg7_t segment pattern, active-high, [6]=a .. [0]=g

module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    input  logic       hex_mode,
    output seg7_t      seg
);

    seg7_t hex_seg;

    always_comb begin
        hex_seg = SEG_BLANK;
        case (code)
            4'hA:    hex_seg = SEG_HA;
            4'hB:    hex_seg = SEG_HB;
            4'hC:    hex_seg = SEG_HC;
            4'hD:    hex_seg = SEG_HD;
            4'hE:    hex_seg = SEG_HE;
            4'hF:    hex_seg = SEG_HF;
            default: hex_seg = SEG_BLANK;
        endcase
    end

    always_comb begin
        seg = SEG_BLANK;
        case (code)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            default: seg = hex_mode ? hex_seg : SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Multiplexed common-segment display driver for NUM_DIGITS digits.
//   A packed code word and per-digit decimal points are latched on a load
//   strobe; digits are then scanned, each for SCAN_DIV cycles of which the
//   first is a dark anti-ghosting cycle. All outputs are registered.
//   Optional feature: define SEG7_LZB_EN to blank leading zeros (digits
//   above digit 0 whose nibble and all higher nibbles are zero).
//   Ports:
//     clk      in   system clock, rising edge
//     rst_n    in   asynchronous reset, active-low
//     enable   in   1: scanning; 0: display dark, scan position held
//     load     in   strobe capturing bcd_in / dp_in (independent of enable)
//     bcd_in   in   [4*NUM_DIGITS-1:0] packed codes, nibble k = digit k
//     dp_in    in   [NUM_DIGITS-1:0]   decimal point per digit
//     seg_out  out  [6:0] segments a..g, active-high
//     dp_out   out  decimal point of the selected digit
//     dig_sel  out  [NUM_DIGITS-1:0] one-hot digit enable, zero when dark

module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int HEX_MODE   = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   dig_sel
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
    logic [NUM_DIGITS-1:0]   dpr_q, dpr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    seg7_t                   seg_q, seg_d;
    logic                    dpo_q, dpo_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;

    logic [NUM_DIGITS-1:0]   lzb_mask;
    logic [3:0]              code_cur;
    logic                    dp_cur;
    logic                    lzb_cur;
    seg7_t                   dec_seg;

`ifdef SEG7_LZB_EN
    // Walk from the most significant digit down; a digit is blanked while
    // every nibble from it upward is zero. Digit 0 always stays visible.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        lzb_mask   = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above & (disp_q[4*k +: 4] == 4'h0);
            if (k > 0) begin
                lzb_mask[k] = zero_above;
            end
        end
    end
`else
    assign lzb_mask = '0;
`endif

    // Select the current digit's code, decimal point and blank flag.
    always_comb begin
        code_cur = 4'h0;
        dp_cur   = 1'b0;
        lzb_cur  = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                code_cur = disp_q[4*k +: 4];
                dp_cur   = dpr_q[k];
                lzb_cur  = lzb_mask[k];
            end
        end
    end

    seg7_decode u_decode (
        .code     (code_cur),
        .hex_mode (HEX_MODE != 0),
        .seg      (dec_seg)
    );

    always_comb begin
        disp_d = disp_q;
        dpr_d  = dpr_q;
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        seg_d  = SEG_BLANK;
        dpo_d  = 1'b0;
        sel_d  = '0;

        if (load) begin
            disp_d = bcd_in;
            dpr_d  = dp_in;
        end

        if (enable) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // cnt_q == 0 is the dark gap between digits to avoid ghosting.
        if (enable && (cnt_q != '0)) begin
            sel_d = NUM_DIGITS'(1) << idx_q;
            seg_d = lzb_cur ? SEG_BLANK : dec_seg;
            dpo_d = dp_cur;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q <= '0;
            dpr_q  <= '0;
            cnt_q  <= '0;
            idx_q  <= '0;
            seg_q  <= SEG_BLANK;
            dpo_q  <= 1'b0;
            sel_q  <= '0;
        end else begin
            disp_q <= disp_d;
            dpr_q  <= dpr_d;
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            seg_q  <= seg_d;
            dpo_q  <= dpo_d;
            sel_q  <= sel_d;
        end
    end

    assign seg_out = seg_q;
    assign dp_out  = dpo_q;
    assign dig_sel = sel_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

    localparam int ND = 4;
    localparam int SD = 4;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic          load;
    logic [15:0]   bcd_in;
    logic [3:0]    dp_in;
    logic [6:0]    seg_out;
    logic          dp_out;
    logic [3:0]    dig_sel;
    logic [6:0]    seg_out_h0;
    logic          dp_out_h0;
    logic [3:0]    dig_sel_h0;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] sel;
        logic [6:0] seg;
        logic [6:0] seg_h0;
        logic       dp;
    } exp_t;

    exp_t sb[$];

    int          m_cnt;
    int          m_idx;
    logic [15:0] m_disp;
    logic [3:0]  m_dp;

    seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .HEX_MODE(1)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .load    (load),
        .bcd_in  (bcd_in),
        .dp_in   (dp_in),
        .seg_out (seg_out),
        .dp_out  (dp_out),
        .dig_sel (dig_sel)
    );

    seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .HEX_MODE(0)) u_dut_h0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .load    (load),
        .bcd_in  (bcd_in),
        .dp_in   (dp_in),
        .seg_out (seg_out_h0),
        .dp_out  (dp_out_h0),
        .dig_sel (dig_sel_h0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] dec(input logic [3:0] c, input bit hex);
        case (c)
            4'h0: return 7'b1111110;
            4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;
            4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;
            4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;
            4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1111011;
            4'hA: return hex ? 7'b1110111 : 7'b0;
            4'hB: return hex ? 7'b0011111 : 7'b0;
            4'hC: return hex ? 7'b1001110 : 7'b0;
            4'hD: return hex ? 7'b0111101 : 7'b0;
            4'hE: return hex ? 7'b1001111 : 7'b0;
            default: return hex ? 7'b1000111 : 7'b0;
        endcase
    endfunction

    function automatic bit lz(input logic [15:0] d, input int k);
`ifdef SEG7_LZB_EN
        return (k > 0) && ((d >> (4 * k)) == 16'h0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_idx  = 0;
        m_disp = 16'h0;
        m_dp   = 4'h0;
    endtask

    // One clock: push the expected registered outputs for this edge, advance
    // the reference model, then pop and compare just after the edge.
    task automatic tick();
        exp_t e;
        logic [3:0] nib;
        e.sel = 4'h0; e.seg = 7'h0; e.seg_h0 = 7'h0; e.dp = 1'b0;
        if (enable && m_cnt != 0) begin
            nib      = m_disp[4*m_idx +: 4];
            e.sel    = 4'b0001 << m_idx;
            e.seg    = lz(m_disp, m_idx) ? 7'h0 : dec(nib, 1'b1);
            e.seg_h0 = lz(m_disp, m_idx) ? 7'h0 : dec(nib, 1'b0);
            e.dp     = m_dp[m_idx];
        end
        sb.push_back(e);
        @(posedge clk);
        if (load) begin
            m_disp = bcd_in;
            m_dp   = dp_in;
        end
        if (enable) begin
            if (m_cnt == SD - 1) begin
                m_cnt = 0;
                m_idx = (m_idx == ND - 1) ? 0 : m_idx + 1;
            end else begin
                m_cnt++;
            end
        end
        #1;
        e = sb.pop_front();
        check("sb_sel", {4'h0, dig_sel}, {4'h0, e.sel});
        check("sb_seg", {1'b0, seg_out}, {1'b0, e.seg});
        check("sb_dp", {7'h0, dp_out}, {7'h0, e.dp});
        check("sb_seg_h0", {1'b0, seg_out_h0}, {1'b0, e.seg_h0});
        check("sb_sel_h0", {4'h0, dig_sel_h0}, {4'h0, e.sel});
    endtask

    // Run until the model reaches the given position (at least one clock).
    task automatic advance_to(input int c, input int i);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(m_cnt == c && m_idx == i) && n < 64);
    endtask

    logic [3:0] scan_sel [16];
    logic [6:0] scan_seg [16];
    logic [6:0] zero_hi;
    logic [6:0] lzb_exp [4];

    initial begin
        scan_sel = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2,
                     4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h8};
        scan_seg = '{7'b0000000, 7'b0110011, 7'b0110011, 7'b0110011,
                     7'b0000000, 7'b1111001, 7'b1111001, 7'b1111001,
                     7'b0000000, 7'b1101101, 7'b1101101, 7'b1101101,
                     7'b0000000, 7'b0110000, 7'b0110000, 7'b0110000};
`ifdef SEG7_LZB_EN
        zero_hi = 7'b0000000;
`else
        zero_hi = 7'b1111110;
`endif
        lzb_exp = '{7'b1111110, 7'b1011011, zero_hi, zero_hi};

        rst_n = 1'b0; enable = 1'b0; load = 1'b0; bcd_in = 16'h0; dp_in = 4'h0;
        model_reset();
        #2;
        check("reset_sel", {4'h0, dig_sel}, 8'h00);
        check("reset_seg", {1'b0, seg_out}, 8'h00);
        check("reset_dp", {7'h0, dp_out}, 8'h00);
        #20;
        rst_n = 1'b1;

        // Scan order with 1234
        enable = 1'b1; load = 1'b1; bcd_in = 16'h1234; dp_in = 4'b0000;
        for (int i = 0; i < 16; i++) begin
            tick();
            load = 1'b0;
            check("scan_sel", {4'h0, dig_sel}, {4'h0, scan_sel[i]});
            check("scan_seg", {1'b0, seg_out}, {1'b0, scan_seg[i]});
        end
        tick();
        check("wrap_blank", {4'h0, dig_sel}, 8'h00);
        tick();
        check("wrap_sel", {4'h0, dig_sel}, 8'h01);
        check("wrap_seg", {1'b0, seg_out}, {1'b0, 7'b0110011});

        // Hex mode with 00AF
        load = 1'b1; bcd_in = 16'h00AF;
        tick();
        load = 1'b0;
        tick();
        check("hex_d0_sel", {4'h0, dig_sel}, 8'h01);
        check("hex_d0_seg", {1'b0, seg_out}, {1'b0, 7'b1000111});
        check("hex0_d0_seg", {1'b0, seg_out_h0}, 8'h00);
        tick();
        tick();
        check("hex_d1_sel", {4'h0, dig_sel}, 8'h02);
        check("hex_d1_seg", {1'b0, seg_out}, {1'b0, 7'b1110111});
        check("hex0_d1_seg", {1'b0, seg_out_h0}, 8'h00);

        // Enable freeze during the 2nd lit cycle of digit 2
        advance_to(3, 2);
        check("pre_freeze_sel", {4'h0, dig_sel}, 8'h04);
        enable = 1'b0;
        tick();
        check("freeze_sel", {4'h0, dig_sel}, 8'h00);
        check("freeze_seg", {1'b0, seg_out}, 8'h00);
        tick();
        tick();
        enable = 1'b1;
        tick();
        check("resume_sel", {4'h0, dig_sel}, 8'h04);
        tick();
        check("resume_gap", {4'h0, dig_sel}, 8'h00);

        // Load latency and decimal point while digit 2 is lit
        advance_to(2, 2);
        load = 1'b1; bcd_in = 16'h9999; dp_in = 4'b0100;
        tick();
        load = 1'b0;
        check("ld_old_seg", {1'b0, seg_out}, {1'b0, zero_hi});
        check("ld_old_dp", {7'h0, dp_out}, 8'h00);
        tick();
        check("ld_new_sel", {4'h0, dig_sel}, 8'h04);
        check("ld_new_seg", {1'b0, seg_out}, {1'b0, 7'b1111011});
        check("ld_new_dp", {7'h0, dp_out}, 8'h01);
        for (int i = 0; i < 16; i++) tick();

        // Async reset mid-frame, between clock edges
        advance_to(3, 1);
        check("pre_rst_sel", {4'h0, dig_sel}, 8'h02);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_sel", {4'h0, dig_sel}, 8'h00);
        check("arst_seg", {1'b0, seg_out}, 8'h00);
        check("arst_dp", {7'h0, dp_out}, 8'h00);
        model_reset();
        #2;
        rst_n = 1'b1;
        tick();
        check("post_rst_gap", {4'h0, dig_sel}, 8'h00);
        tick();
        check("post_rst_sel", {4'h0, dig_sel}, 8'h01);
        check("post_rst_seg", {1'b0, seg_out}, {1'b0, 7'b1111110});
        for (int i = 0; i < 16; i++) tick();

        // Leading zeros with 0050
        load = 1'b1; bcd_in = 16'h0050; dp_in = 4'b0000;
        tick();
        load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            advance_to(2, k);
            check("lzb_sel", {4'h0, dig_sel}, {4'h0, 4'b0001 << k});
            check("lzb_seg", {1'b0, seg_out}, {1'b0, lzb_exp[k]});
        end

        check("sb_empty", 8'(sb.size()), 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised successor to the single-digit BCD/hex-to-7-segment decoder.
- Drives a multiplexed common-segment display of NUM_DIGITS digits.
- Latches a packed BCD/hex word on a load strobe, then time-multiplexes the digits with a programmable dwell time.
- Inserts an anti-ghosting blank cycle between digits; optional leading-zero blanking.
- Sits between the counter/datapath logic and the board's display pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8)
SCAN_DIV, 1000, clock cycles per digit period (>=2), including the 1 blank cycle
HEX_MODE, 1, 1: codes 10-15 show A,b,C,d,E,F; 0: codes 10-15 blank all segments

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous reset, active-low
enable  input  1  1: scanning active; 0: display dark, scan frozen
load  input  1  single-cycle strobe; captures bcd_in and dp_in
bcd_in  input  4*NUM_DIGITS  packed codes; nibble k = digit k; digit 0 = least significant
dp_in  input  NUM_DIGITS  decimal point per digit
seg_out  output  7  segments, active-high; [6]=a, [5]=b … [0]=g
dp_out  output  1  decimal point of the currently selected digit
dig_sel  output  NUM_DIGITS  one-hot digit enable, active-high; all-zero when dark

Behaviour:
- Reset (async assert, sync release): display register = 0, dp register = 0, cnt = 0, idx = 0, seg_out = 0, dp_out = 0, dig_sel = 0.
- Load path:
  - On load=1 at a rising edge, the display register takes bcd_in and the dp register takes dp_in.
  - Load is honoured regardless of enable.
  - Effect reaches the outputs on the following edge (2-cycle latency from load to seg_out), if that digit is selected.
- Scan counter:
  - When enable=1, cnt increments 0..SCAN_DIV-1.
  - At cnt==SCAN_DIV-1, cnt wraps to 0 and idx advances.
  - idx wraps NUM_DIGITS-1 -> 0.
  - When enable=0, cnt and idx hold.
- Output register, updated every edge from the registered cnt/idx, so outputs lag cnt/idx by 1 cycle:
  - If enable=0 or cnt==0 (blank cycle): dig_sel = 0, seg_out = 0, dp_out = 0.
  - Otherwise: dig_sel = 1<<idx, seg_out = decode(nibble idx), dp_out = dp[idx].
- Per digit period: 1 blank cycle plus SCAN_DIV-1 lit cycles. Full frame = NUM_DIGITS*SCAN_DIV cycles.
- Decode table (abcdefg):
  - 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001, 4 = 0110011
  - 5 = 1011011, 6 = 1011111, 7 = 1110000, 8 = 1111111, 9 = 1111011
  - A = 1110111, b = 0011111, C = 1001110, d = 0111101, E = 1001111, F = 1000111
- enable falling mid-period: outputs go dark on the next edge. On re-enable, scanning resumes at the held cnt/idx.
- load coinciding with an idx advance: the new digit shows the new data one edge later; no stale data persists beyond 1 cycle.
- rst_n asserted mid-scan: all outputs go to 0 immediately, without waiting for a clock edge.

Optional Feature:
- SEG7_LZB_EN defined (leading-zero blanking):
  - Any digit k>0 whose nibble and all higher nibbles are 0 drives seg_out = 0.
  - dig_sel and dp_out still behave normally for that digit.
  - Digit 0 is never blanked.
  - Blank mask is computed combinationally from the display register.
- Not defined: all digits decode normally; zeros shown as 1111110.

Decomposition:
- Shared package seg7_pkg:
  - segment-pattern constants SEG_0..SEG_F and SEG_BLANK;
  - bit-position constants for a..g;
  - typedef seg7_t (7-bit).
- One natural sub-module: seg7_decode. Combinational; inputs code[3:0] and hex_mode; output seg7_t. Instantiated once, muxed by idx.

Test Plan (NUM_DIGITS=4, SCAN_DIV=4):
- Scan order: reset, load bcd_in=16'h1234, dp_in=4'b0000, enable=1 -> dig_sel repeats 0000, 0001 x3, 0000, 0010 x3, 0000, 0100 x3, 0000, 1000 x3, then wraps to 0001. seg_out = 0110011 with 0001, 1111001 with 0010, 1101101 with 0100, 0110000 with 1000.
- Hex mode: load 16'h00AF. HEX_MODE=1 -> digit0 = 1000111, digit1 = 1110111. HEX_MODE=0 -> both 0000000.
- Enable freeze: deassert enable during the 2nd lit cycle of digit 2 -> next edge dig_sel = 0, seg_out = 0. Re-enable -> digit 2 resumes with 1 remaining lit cycle.
- Load latency and decimal point: load 16'h9999 with dp_in=4'b0100 while digit 2 is lit -> seg_out = 1111011 and dp_out=1 two edges after the load. dp_out=0 on the other digits.
- Async reset: pull rst_n low between clock edges mid-frame -> all outputs 0 with no clock. After release and enable=1 -> first lit digit is 0, display shows 0 (1111110, or blank digits 1-3 with SEG7_LZB_EN).
- Leading-zero blanking (SEG7_LZB_EN): load 16'h0050 -> digits 3 and 2 seg_out = 0 with dig_sel pulsing. Digit 1 = 1011011, digit 0 = 1111110.
